fc_layer_engine: RTL and testbench

Parametrised fully-connected layer engine for the detection network classifier head. It loads one input vector as MAC_UNITS-lane beats into an internal buffer. It then reuses that buffer for every output node, streaming weights and biases from external synchronous ROMs. Arithmetic is signed fixed point with bias add, saturation and optional ReLU. It is sequenced by the shared 4-bit `state` bus alongside the convolution and pooling engines.

---
 rtl/fc_layer_engine.sv | 145 ++++++++++++++
 tb/tb_fc_layer_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - fully-connected layer engine: buffered input vector, ROM-streamed weights, saturating fixed-point output
module fc_layer_engine #(
    parameter int DATAWIDTH    = 16,
    parameter int FRAC_BITS    = 8,
    parameter int INPUT_NODES  = 784,
    parameter int OUTPUT_NODES = 2,
    parameter int MAC_UNITS    = 16,
    parameter int FC_STATE     = 11,
    parameter int RELU_EN      = 0,
    localparam int BEATS = (INPUT_NODES + MAC_UNITS - 1) / MAC_UNITS,
    localparam int ACC_W = 2 * DATAWIDTH + $clog2(INPUT_NODES) + 1,
    localparam int WA_W  = (OUTPUT_NODES * BEATS > 1) ? $clog2(OUTPUT_NODES * BEATS) : 1,
    localparam int BA_W  = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        state,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATAWIDTH*MAC_UNITS-1:0]    in_data,
    output logic [WA_W-1:0]                   w_addr,
    input  logic [DATAWIDTH*MAC_UNITS-1:0]    w_data,
    output logic [BA_W-1:0]                   b_addr,
    input  logic [DATAWIDTH-1:0]              b_data,
    output logic [DATAWIDTH*OUTPUT_NODES-1:0] output_data,
    output logic                              done
);
    localparam int BI_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CY_W = $clog2(BEATS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} fsm_t;

    fsm_t                              r_fsm, w_fsm_nxt;
    logic [BI_W-1:0]                   r_beat;
    logic [CY_W-1:0]                   r_cyc;
    logic [BA_W-1:0]                   r_node;
    logic [WA_W-1:0]                   r_waddr;
    logic signed [ACC_W-1:0]           r_acc;
    logic [DATAWIDTH*OUTPUT_NODES-1:0] r_out;
    logic [DATAWIDTH*MAC_UNITS-1:0]    r_buf [BEATS];

    logic                              w_sel, w_accept, w_last_beat, w_mac_end, w_last_node;
    logic [BI_W-1:0]                   w_bidx;
    logic signed [2*DATAWIDTH-1:0]     w_prod;
    logic signed [ACC_W-1:0]           w_sum, w_bias_ext, w_biased, w_shift;
    logic [ACC_W-DATAWIDTH:0]          w_hi;
    logic [DATAWIDTH-1:0]              w_sat, w_result;

    assign w_sel       = (state == 4'(FC_STATE));
    assign w_accept    = (r_fsm == S_LOAD) && in_valid;
    assign w_last_beat = (r_beat == BI_W'(BEATS - 1));
    assign w_mac_end   = (r_cyc == CY_W'(BEATS));
    assign w_last_node = (r_node == BA_W'(OUTPUT_NODES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_sel) w_fsm_nxt = S_LOAD;
            S_LOAD:  if (!w_sel) w_fsm_nxt = S_IDLE;
                     else if (w_accept && w_last_beat) w_fsm_nxt = S_MAC;
            S_MAC:   if (!w_sel) w_fsm_nxt = S_IDLE;
                     else if (w_mac_end) w_fsm_nxt = S_WRITE;
            S_WRITE: if (!w_sel) w_fsm_nxt = S_IDLE;
                     else w_fsm_nxt = w_last_node ? S_DONE : S_MAC;
            S_DONE:  if (!w_sel) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // MAC cycle c consumes the weight beat addressed in cycle c-1, so the buffer index lags by one
    always_comb begin
        w_bidx = (r_cyc == '0) ? '0 : BI_W'(r_cyc - 1'b1);
        w_sum  = '0;
        w_prod = '0;
        for (int i = 0; i < MAC_UNITS; i++) begin
            w_prod = $signed(r_buf[w_bidx][i*DATAWIDTH +: DATAWIDTH]) *
                     $signed(w_data[i*DATAWIDTH +: DATAWIDTH]);
            if ((int'(w_bidx) * MAC_UNITS + i) < INPUT_NODES)
                w_sum = w_sum + {{(ACC_W-2*DATAWIDTH){w_prod[2*DATAWIDTH-1]}}, w_prod};
        end
    end

    assign w_bias_ext = {{(ACC_W-DATAWIDTH){b_data[DATAWIDTH-1]}}, b_data};
    assign w_biased   = r_acc + (w_bias_ext <<< FRAC_BITS);
    assign w_shift    = w_biased >>> FRAC_BITS;
    assign w_hi       = w_shift[ACC_W-1:DATAWIDTH-1];

    always_comb begin
        w_sat = w_shift[DATAWIDTH-1:0];
        if (!((&w_hi) || (~|w_hi)))
            w_sat = w_shift[ACC_W-1] ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
        w_result = ((RELU_EN != 0) && w_sat[DATAWIDTH-1]) ? '0 : w_sat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat  <= '0;
            r_cyc   <= '0;
            r_node  <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
            r_out   <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_beat  <= '0;
                    r_cyc   <= '0;
                    r_node  <= '0;
                    r_waddr <= '0;
                    r_acc   <= '0;
                end
                S_LOAD: if (w_accept) r_beat <= r_beat + 1'b1;
                S_MAC: begin
                    r_cyc <= w_mac_end ? '0 : r_cyc + 1'b1;
                    if (r_cyc != '0) r_acc <= r_acc + w_sum;
                    if (r_cyc < CY_W'(BEATS - 1)) r_waddr <= r_waddr + 1'b1;
                end
                S_WRITE: if (w_sel) begin
                    r_out[r_node*DATAWIDTH +: DATAWIDTH] <= w_result;
                    if (!w_last_node) begin
                        r_node  <= r_node + 1'b1;
                        r_acc   <= '0;
                        r_waddr <= WA_W'((int'(r_node) + 1) * BEATS);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_beat] <= in_data;
    end

    assign in_ready    = (r_fsm == S_LOAD);
    assign done        = (r_fsm == S_DONE);
    assign w_addr      = r_waddr;
    assign b_addr      = r_node;
    assign output_data = r_out;
endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - random and directed checks of fc_layer_engine against an arithmetic reference model
module tb_fc_layer_engine;
    localparam int DW = 16, FB = 8, IN = 20, ON = 2, MU = 16, FCS = 11;
    localparam int BEATS = 2, LAT = ON * (BEATS + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, in_valid, in_ready, in_ready_r, done, done_r;
    logic [3:0]        state;
    logic [DW*MU-1:0]  in_data, w_data, w_data_r;
    logic [1:0]        w_addr, w_addr_r;
    logic [0:0]        b_addr, b_addr_r;
    logic [DW-1:0]     b_data, b_data_r;
    logic [DW*ON-1:0]  out0, out1, exp0, exp1;

    logic [DW*MU-1:0]  wrom [ON*BEATS];
    logic [DW-1:0]     brom [ON];
    logic [DW-1:0]     xv [BEATS*MU];
    logic [DW-1:0]     wv [ON][BEATS*MU];
    logic [DW-1:0]     bv [ON];
    int n_chk = 0, n_err = 0;

    fc_layer_engine #(.DATAWIDTH(DW), .FRAC_BITS(FB), .INPUT_NODES(IN), .OUTPUT_NODES(ON),
                      .MAC_UNITS(MU), .FC_STATE(FCS), .RELU_EN(0)) dut (
        .clk(clk), .reset(rst_n), .state(state), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
        .output_data(out0), .done(done));

    fc_layer_engine #(.DATAWIDTH(DW), .FRAC_BITS(FB), .INPUT_NODES(IN), .OUTPUT_NODES(ON),
                      .MAC_UNITS(MU), .FC_STATE(FCS), .RELU_EN(1)) dut_r (
        .clk(clk), .reset(rst_n), .state(state), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .w_addr(w_addr_r), .w_data(w_data_r), .b_addr(b_addr_r), .b_data(b_data_r),
        .output_data(out1), .done(done_r));

    always @(posedge clk) begin
        w_data   <= wrom[w_addr];
        w_data_r <= wrom[w_addr_r];
        b_data   <= brom[b_addr];
        b_data_r <= brom[b_addr_r];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_roms();
        for (int k = 0; k < ON; k++) begin
            brom[k] = bv[k];
            for (int r = 0; r < BEATS; r++)
                for (int i = 0; i < MU; i++)
                    wrom[k*BEATS+r][i*DW +: DW] = wv[k][r*MU+i];
        end
    endtask

    // Lanes beyond IN are padded with values that would corrupt the result if not masked
    task automatic fill_const(input logic [15:0] x, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] b0, input logic [15:0] b1);
        for (int j = 0; j < BEATS*MU; j++) begin
            xv[j]    = (j < IN) ? x  : 16'h7FFF;
            wv[0][j] = (j < IN) ? w0 : 16'h7FFF;
            wv[1][j] = (j < IN) ? w1 : 16'h7FFF;
        end
        bv[0] = b0;
        bv[1] = b1;
        sync_roms();
    endtask

    task automatic fill_rand();
        for (int j = 0; j < BEATS*MU; j++) begin
            xv[j] = (j < IN) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
            for (int k = 0; k < ON; k++)
                wv[k][j] = (j < IN) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
        end
        for (int k = 0; k < ON; k++) bv[k] = 16'($urandom_range(0, 4095) - 2048);
        sync_roms();
    endtask

    function automatic logic [15:0] ref_node(input int k, input bit relu);
        longint acc = 0;
        longint r;
        for (int j = 0; j < IN; j++)
            acc += longint'($signed(xv[j])) * longint'($signed(wv[k][j]));
        acc += longint'($signed(bv[k])) * (longint'(1) << FB);
        r = acc >>> FB;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return 16'(r);
    endfunction

    task automatic calc_exp();
        for (int k = 0; k < ON; k++) begin
            exp0[k*DW +: DW] = ref_node(k, 1'b0);
            exp1[k*DW +: DW] = ref_node(k, 1'b1);
        end
    endtask

    task automatic send_beat(input int b);
        in_valid = 1'b1;
        for (int i = 0; i < MU; i++) in_data[i*DW +: DW] = xv[b*MU+i];
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        @(negedge clk);
        state = 4'(FCS);
        in_valid = 1'b0;
        chk({tag, " ready_idle"}, in_ready, 0);
        while (!in_ready && cnt < 10) begin @(negedge clk); cnt++; end
        chk({tag, " ready_latency"}, cnt, 1);
    endtask

    task automatic run_pass(input bit gaps, input string tag);
        int cnt;
        bit rdy_bad = 1'b0;
        wait_ready(tag);
        for (int b = 0; b < BEATS; b++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = {8{$urandom}};
                @(negedge clk);
            end
            send_beat(b);
        end
        in_valid = 1'b0;
        calc_exp();
        cnt = 0;
        while (!done && cnt < 50) begin
            if (gaps) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {8{$urandom}};
            end
            @(negedge clk);
            cnt++;
            if (in_ready) rdy_bad = 1'b1;
        end
        in_valid = 1'b0;
        chk({tag, " done_latency"}, cnt, LAT);
        chk({tag, " ready_low_outside_load"}, rdy_bad, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " done_relu"}, done_r, 1);
        chk({tag, " out"}, out0, exp0);
        chk({tag, " out_relu"}, out1, exp1);
        @(negedge clk);
        chk({tag, " done_hold"}, done, 1);
        state = 4'd0;
        @(negedge clk);
        chk({tag, " done_drop"}, done, 0);
    endtask

    initial begin
        rst_n = 1'b0; state = 4'd0; in_valid = 1'b0; in_data = '0;
        fill_const(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst done", done, 0);
        chk("rst out", out0, 0);
        chk("rst w_addr", w_addr, 0);
        chk("rst b_addr", b_addr, 0);
        rst_n = 1'b1;

        in_valid = 1'b1;
        in_data  = {8{$urandom}};
        repeat (3) @(negedge clk);
        chk("idle ignores valid", in_ready, 0);
        in_valid = 1'b0;

        fill_const(16'h0100, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
        run_pass(1'b0, "partial");
        chk("partial literal", out0, {16'h0A00, 16'h0A00});
        run_pass(1'b1, "partial_gaps");

        fill_const(16'h0100, 16'h0100, 16'hFF00, 16'h0200, 16'h0000);
        run_pass(1'b0, "bias");
        chk("bias literal", out0, {16'hEC00, 16'h1600});
        chk("bias relu literal", out1, {16'h0000, 16'h1600});

        fill_const(16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
        run_pass(1'b0, "sat");
        chk("sat literal", out0, {16'h8000, 16'h7FFF});

        for (int t = 0; t < 3; t++) begin
            fill_rand();
            run_pass(1'b1, $sformatf("rand%0d", t));
        end

        fill_rand();
        wait_ready("abort");
        for (int b = 0; b < BEATS; b++) send_beat(b);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        state = 4'd1;
        @(negedge clk);
        chk("abort in_ready", in_ready, 0);
        chk("abort done", done, 0);
        chk("abort out kept", out0, exp0);
        repeat (12) @(negedge clk);
        chk("abort done stays low", done, 0);
        chk("abort out still kept", out0, exp0);
        chk("abort relu out kept", out1, exp1);
        run_pass(1'b1, "after_abort");

        fill_rand();
        wait_ready("reset_load");
        send_beat(0);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 0);
        chk("midrst done", done, 0);
        chk("midrst out", out0, 0);
        chk("midrst out_relu", out1, 0);
        chk("midrst w_addr", w_addr, 0);
        chk("midrst b_addr", b_addr, 0);
        in_valid = 1'b0;
        state = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(1'b1, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
